// File: rtl/mac_array_pkg.sv
// Shared types and width helpers for the MAC array engine and its lanes.
package mac_array_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_FILT,
        ST_COMPUTE,
        ST_OUTPUT,
        ST_FINISH
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Accumulator width: full product plus headroom for summing K products.
    function automatic int acc_width(input int dw, input int k);
        return 2 * dw + clog2(k);
    endfunction

    function automatic int idx_width(input int k);
        return (k > 1) ? clog2(k) : 1;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: K-entry signed weight file plus a full-width signed accumulator.
module mac_lane
    import mac_array_pkg::*;
#(
    parameter int DW = 8,
    parameter int K  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 w_we,
    input  logic [idx_width(K)-1:0]              w_idx,
    input  logic [DW-1:0]                        w_data,
    input  logic                                 x_vld,
    input  logic                                 x_first,
    input  logic [DW-1:0]                        x,
    output logic signed [acc_width(DW, K)-1:0]   acc
);
    localparam int ACCW = acc_width(DW, K);

    logic signed [DW-1:0]   w [K];
    logic signed [2*DW-1:0] prod;

    assign prod = $signed(x) * w[w_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < K; k++) w[k] <= '0;
        end else if (w_we) begin
            w[w_idx] <= w_data;
        end
    end

    // Tap 0 reloads the accumulator so no separate clear cycle is needed per window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (x_vld) begin
            acc <= x_first ? ACCW'(prod) : acc + ACCW'(prod);
        end
    end

endmodule

// File: rtl/mac_array_engine.sv
// P-lane MAC engine: loads K taps of per-lane weights, then streams n_win windows of
// broadcast samples. Define MAC_ARRAY_RELU_EN to clamp negative lane results to 0.
module mac_array_engine
    import mac_array_pkg::*;
#(
    parameter int P  = 4,
    parameter int DW = 8,
    parameter int AW = 9,
    parameter int K  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [AW-1:0]                  filt_base,
    input  logic [AW-1:0]                  ifm_base,
    input  logic [AW-1:0]                  out_base,
    input  logic [3:0]                     stride,
    input  logic [AW-1:0]                  n_win,
    output logic                           mem_rd_en,
    output logic [AW-1:0]                  mem_rd_addr,
    input  logic [P*DW-1:0]                mem_rd_data,
    output logic                           out_valid,
    output logic [AW-1:0]                  out_addr,
    output logic [P*acc_width(DW, K)-1:0]  out_data,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done,
    output state_t                         dbg_state
);
    localparam int ACCW = acc_width(DW, K);
    localparam int TW   = idx_width(K);

    state_t          state;
    logic [TW-1:0]   cnt;
    logic            rd_vld_q;
    logic            rd_filt_q;
    logic [TW-1:0]   rd_tap_q;
    logic [AW-1:0]   ifm_q;
    logic [AW-1:0]   out_base_q;
    logic [3:0]      stride_q;
    logic [AW-1:0]   n_win_q;
    logic [AW-1:0]   win_addr;
    logic [AW-1:0]   win_n;
    logic            last_cap;

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;
    assign last_cap  = rd_vld_q && (rd_tap_q == TW'(K - 1));

    // Output handshake: out_valid rises with out_addr/out_data settled and holds them
    // unchanged until out_ready; a result transfers on every edge where both are high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            rd_vld_q    <= 1'b0;
            rd_filt_q   <= 1'b0;
            rd_tap_q    <= '0;
            ifm_q       <= '0;
            out_base_q  <= '0;
            stride_q    <= '0;
            n_win_q     <= '0;
            win_addr    <= '0;
            win_n       <= '0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            done        <= 1'b0;
        end else begin
            rd_vld_q  <= mem_rd_en;
            rd_filt_q <= (state == ST_LOAD_FILT);
            rd_tap_q  <= cnt;
            done      <= 1'b0;
            // Burst issue: K back-to-back reads from wherever the burst was started.
            if (mem_rd_en) begin
                if (cnt == TW'(K - 1)) begin
                    mem_rd_en <= 1'b0;
                end else begin
                    cnt         <= cnt + TW'(1);
                    mem_rd_addr <= mem_rd_addr + AW'(1);
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ifm_q       <= ifm_base;
                        out_base_q  <= out_base;
                        stride_q    <= stride;
                        n_win_q     <= n_win;
                        state       <= ST_LOAD_FILT;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= filt_base;
                        cnt         <= '0;
                    end
                end
                ST_LOAD_FILT: begin
                    if (last_cap) begin
                        if (n_win_q == '0) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state       <= ST_COMPUTE;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= ifm_q;
                            cnt         <= '0;
                            win_addr    <= ifm_q;
                            win_n       <= '0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (last_cap) begin
                        state     <= ST_OUTPUT;
                        out_valid <= 1'b1;
                        out_addr  <= out_base_q + win_n;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (win_n + AW'(1) == n_win_q) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state       <= ST_COMPUTE;
                            win_n       <= win_n + AW'(1);
                            win_addr    <= win_addr + AW'(stride_q);
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= win_addr + AW'(stride_q);
                            cnt         <= '0;
                        end
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < P; i++) begin : g_lane
        logic signed [ACCW-1:0] acc;

        mac_lane #(.DW(DW), .K(K)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .w_we    (rd_vld_q && rd_filt_q),
            .w_idx   (rd_tap_q),
            .w_data  (mem_rd_data[i*DW +: DW]),
            .x_vld   (rd_vld_q && !rd_filt_q),
            .x_first (rd_tap_q == '0),
            .x       (mem_rd_data[DW-1:0]),
            .acc     (acc)
        );

`ifdef MAC_ARRAY_RELU_EN
        assign out_data[i*ACCW +: ACCW] = acc[ACCW-1] ? '0 : acc;
`else
        assign out_data[i*ACCW +: ACCW] = acc;
`endif
    end

endmodule

// File: tb/tb_mac_array_engine.sv
// Directed bench for mac_array_engine (P=4, K=4) with a 1-cycle-latency memory model.
module tb_mac_array_engine;
    import mac_array_pkg::*;

    localparam int P    = 4;
    localparam int DW   = 8;
    localparam int AW   = 9;
    localparam int K    = 4;
    localparam int ACCW = acc_width(DW, K);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     filt_base = '0;
    logic [AW-1:0]     ifm_base = '0;
    logic [AW-1:0]     out_base = '0;
    logic [3:0]        stride = '0;
    logic [AW-1:0]     n_win = '0;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_rd_addr;
    logic [P*DW-1:0]   mem_rd_data = '0;
    logic              out_valid;
    logic [AW-1:0]     out_addr;
    logic [P*ACCW-1:0] out_data;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;
    state_t            dbg_state;

    logic [P*DW-1:0]   mem [1 << AW];
    logic [AW-1:0]     exp_q[$];
    logic [AW-1:0]     rd_q[$];
    bit                log_en = 1'b0;
    int                n_cmp = 0;
    int                n_fail = 0;
    int                valid_cycles = 0;
    logic [P*ACCW-1:0] d_hold;

    mac_array_engine #(.P(P), .DW(DW), .AW(AW), .K(K)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .filt_base   (filt_base),
        .ifm_base    (ifm_base),
        .out_base    (out_base),
        .stride      (stride),
        .n_win       (n_win),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // Clock / memory / monitor
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    always @(negedge clk) begin
        if (log_en && mem_rd_en) rd_q.push_back(mem_rd_addr);
        if (out_valid) valid_cycles++;
    end

    // Checkers and driver tasks
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef MAC_ARRAY_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check_lanes(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e [P];
        logic [ACCW-1:0] ev;
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < P; i++) begin
            ev = ACCW'(e[i]);
            check($sformatf("%s lane%0d", tag, i), 64'(out_data[i*ACCW +: ACCW]), 64'(ev));
        end
    endtask

    task automatic start_job(input int fb, input int ib, input int ob, input int st, input int nw);
        @(negedge clk);
        filt_base = AW'(fb);
        ifm_base  = AW'(ib);
        out_base  = AW'(ob);
        stride    = 4'(st);
        n_win     = AW'(nw);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " out_valid seen"}, 64'(out_valid), 64'(1));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done"}, 64'(done), 64'(1));
        @(negedge clk);
        check({tag, " done single cycle"}, 64'(done), 64'(0));
        check({tag, " busy after done"}, 64'(busy), 64'(0));
    endtask

    task automatic check_reads(input string tag);
        check({tag, " read count"}, 64'(rd_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && rd_q.size() > 0) begin
            check({tag, " read addr"}, 64'(rd_q.pop_front()), 64'(exp_q.pop_front()));
        end
        exp_q.delete();
        rd_q.delete();
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        for (int j = 0; j < 4; j++) mem[j] = {8'd1, 8'd1, 8'd1, 8'd1};
        for (int j = 0; j < 5; j++) mem[16 + j] = {8'h7F, 8'h80, 8'h55, 8'(j + 1)};
        for (int j = 0; j < 4; j++) mem[32 + j] = {8'h00, 8'h02, 8'hFF, 8'h01};
        for (int j = 0; j < 4; j++) mem[40 + j] = {8'(j + 9), 8'hC3, 8'hF0, 8'd3};
        for (int j = 0; j < 4; j++) mem[48 + j] = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int j = 0; j < 4; j++) mem[60 + j] = {8'(j + 1), 8'h11, 8'h22, 8'h33};
        mem[510] = {8'hAA, 8'hAA, 8'hAA, 8'd5};
        mem[511] = {8'hAA, 8'hAA, 8'hAA, 8'd6};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst out_valid", 64'(out_valid), 64'(0));
        check("rst mem_rd_en", 64'(mem_rd_en), 64'(0));
        check("rst mem_rd_addr", 64'(mem_rd_addr), 64'(0));
        check("rst out_addr", 64'(out_addr), 64'(0));
        check("rst out_data", 64'(out_data), 64'(0));
        check("rst state", 64'(dbg_state), 64'(ST_IDLE));
        rst_n = 1'b1;

        // Unit weights, ramp 1..5, two windows, zero-wait output
        out_ready = 1'b1;
        log_en = 1'b1;
        for (int j = 0; j < 4; j++) exp_q.push_back(AW'(j));
        for (int j = 0; j < 4; j++) exp_q.push_back(AW'(16 + j));
        for (int j = 0; j < 4; j++) exp_q.push_back(AW'(17 + j));
        start_job(0, 16, 100, 1, 2);
        check("job1 busy", 64'(busy), 64'(1));
        wait_valid("job1 w0");
        check("job1 w0 out_addr", 64'(out_addr), 64'(100));
        check_lanes("job1 w0", 10, 10, 10, 10);
        @(negedge clk);
        check("job1 zero-wait transfer", 64'(out_valid), 64'(0));
        wait_valid("job1 w1");
        check("job1 w1 out_addr", 64'(out_addr), 64'(101));
        check_lanes("job1 w1", 14, 14, 14, 14);
        wait_done("job1");
        check_reads("job1");

        // Signed lane weights 1,-1,2,0 with x=3; hold out_ready low for 5 cycles
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) exp_q.push_back(AW'(32 + j));
        for (int j = 0; j < 4; j++) exp_q.push_back(AW'(40 + j));
        start_job(32, 40, 200, 1, 1);
        wait_valid("job2");
        check("job2 out_addr", 64'(out_addr), 64'(200));
        check_lanes("job2", relu(12), relu(-12), relu(24), relu(0));
        d_hold = out_data;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("job2 hold%0d out_valid", c), 64'(out_valid), 64'(1));
            check($sformatf("job2 hold%0d out_addr", c), 64'(out_addr), 64'(200));
            check($sformatf("job2 hold%0d out_data", c), 64'(out_data), 64'(d_hold));
            check($sformatf("job2 hold%0d mem_rd_en", c), 64'(mem_rd_en), 64'(0));
            start = (c == 2);
            @(negedge clk);
        end
        start = 1'b0;
        check("job2 state after hold", 64'(dbg_state), 64'(ST_OUTPUT));
        check_lanes("job2 after hold", relu(12), relu(-12), relu(24), relu(0));
        out_ready = 1'b1;
        @(negedge clk);
        check("job2 transfer", 64'(out_valid), 64'(0));
        wait_done("job2");
        check_reads("job2");

        // n_win = 0: filter load only, then done, never out_valid
        valid_cycles = 0;
        for (int j = 0; j < 4; j++) exp_q.push_back(AW'(60 + j));
        start_job(60, 16, 300, 1, 0);
        wait_done("job3");
        check("job3 no out_valid", 64'(valid_cycles), 64'(0));
        check_reads("job3");

        // Address wrap: ifm_base 510, out_base 511
        for (int j = 0; j < 4; j++) exp_q.push_back(AW'(48 + j));
        exp_q.push_back(AW'(510)); exp_q.push_back(AW'(511));
        exp_q.push_back(AW'(0));   exp_q.push_back(AW'(1));
        exp_q.push_back(AW'(511)); exp_q.push_back(AW'(0));
        exp_q.push_back(AW'(1));   exp_q.push_back(AW'(2));
        start_job(48, 510, 511, 1, 2);
        wait_valid("job4 w0");
        check("job4 w0 out_addr", 64'(out_addr), 64'(511));
        check_lanes("job4 w0", 13, 26, 39, 52);
        @(negedge clk);
        wait_valid("job4 w1");
        check("job4 w1 out_addr wrap", 64'(out_addr), 64'(0));
        check_lanes("job4 w1", 9, 18, 27, 36);
        wait_done("job4");
        check_reads("job4");
        log_en = 1'b0;

        // Asynchronous reset in the middle of COMPUTE
        start_job(0, 16, 100, 1, 2);
        begin
            int n;
            n = 0;
            while (!(dbg_state == ST_COMPUTE && mem_rd_en === 1'b1) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("mid reset reached compute", 64'(dbg_state), 64'(ST_COMPUTE));
        rst_n = 1'b0;
        #1;
        check("mid reset busy", 64'(busy), 64'(0));
        check("mid reset out_valid", 64'(out_valid), 64'(0));
        check("mid reset mem_rd_en", 64'(mem_rd_en), 64'(0));
        check("mid reset state", 64'(dbg_state), 64'(ST_IDLE));
        check("mid reset out_data", 64'(out_data), 64'(0));
        check("mid reset mem_rd_addr", 64'(mem_rd_addr), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset idle", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_array_engine.md
MAC_ARRAY_ENGINE -- requirements
Module: mac_array_engine

Interface
REQ-001 SHALL have parameter P, default 4: number of MAC lanes (output channels).
REQ-002 SHALL have parameter DW, default 8: signed sample and weight width.
REQ-003 SHALL have parameter AW, default 9: memory address width.
REQ-004 SHALL have parameter K, default 16: taps per window.
REQ-005 SHALL have ports clk in 1 (single clock) and rst_n in 1 (reset, asynchronous, active-low).
REQ-006 SHALL have port start in 1: begin job, sampled in IDLE only.
REQ-007 SHALL have ports filt_base, ifm_base, out_base in AW each: job base addresses, latched on start.
REQ-008 SHALL have ports stride in 4 (window step) and n_win in AW (window count), both latched on start.
REQ-009 SHALL have ports mem_rd_en out 1 and mem_rd_addr out AW: read request.
REQ-010 SHALL have port mem_rd_data in P*DW: read data, fixed 1-cycle latency after mem_rd_en.
REQ-011 SHALL have ports out_valid out 1, out_addr out AW, out_data out P*ACCW, out_ready in 1, where ACCW = 2*DW + clog2(K).
REQ-012 SHALL have ports busy out 1 (high outside IDLE) and done out 1 (single-cycle pulse).

Function
REQ-013 SHALL implement FSM IDLE -> LOAD_FILT -> COMPUTE -> OUTPUT -> (COMPUTE | FINISH) -> IDLE.
REQ-014 SHALL leave IDLE on start=1, latching all job inputs and entering LOAD_FILT next cycle.
REQ-015 SHALL in LOAD_FILT issue K consecutive reads at filt_base+k and store word k lane i (bits [i*DW+:DW]) as weight w[i][k].
REQ-016 SHALL in COMPUTE for window n issue K consecutive reads at ifm_base+n*stride+k; sample = bits [DW-1:0], broadcast to all lanes.
REQ-017 SHALL load acc[i] = x*w[i][0] on tap 0 and add x*w[i][k] on later taps, signed, full ACCW width, no overflow.
REQ-018 SHALL enter OUTPUT one cycle after the last tap's data returns, asserting out_valid with out_addr = out_base+n.
REQ-019 SHALL hold out_valid, out_addr, out_data stable until out_ready=1; the transfer occurs on the edge where both are high.
REQ-020 SHALL after transfer go to COMPUTE for n+1, or to FINISH if n+1 = n_win.
REQ-021 SHALL in FINISH pulse done for one cycle, then return to IDLE.
REQ-022 SHALL go from LOAD_FILT directly to FINISH when n_win = 0, with no out_valid.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL wrap all address arithmetic modulo 2^AW.
REQ-025 SHALL keep mem_rd_en low in OUTPUT, FINISH and IDLE.
REQ-026 SHALL accept out_ready already high on the first out_valid cycle (zero-wait transfer).

Reset
REQ-027 SHALL on rst_n=0, asynchronously and at any state including mid-job, enter IDLE and drive busy, done, out_valid and mem_rd_en to 0.
REQ-028 SHALL on rst_n=0 clear out_data, out_addr, mem_rd_addr, the accumulators and the weights to 0.

Configuration
REQ-029 SHALL, when MAC_ARRAY_RELU_EN is defined, clamp negative lane results to 0 on out_data.
REQ-030 SHALL, when MAC_ARRAY_RELU_EN is undefined, pass raw signed accumulators to out_data.

Structure
REQ-031 SHALL place the FSM state enum and the ACCW/clog2 helper function in shared package mac_array_pkg.
REQ-032 SHALL implement one lane (weight register file plus MAC accumulator) as sub-module mac_lane, instantiated P times by generate.

Verification
REQ-033 Bench SHALL cover: P=4, K=4, all weights 1, ifm = 1,2,3,4,5, stride 1, n_win 2 -> out_data lanes 10 then 14, out_addr out_base, out_base+1.
REQ-034 Bench SHALL cover: lane weights 1,-1,2,0 with x=3 on every tap (K=4) -> lanes 12, -12, 24, 0; with MAC_ARRAY_RELU_EN -> 12, 0, 24, 0.
REQ-035 Bench SHALL cover: out_ready held low 5 cycles -> out_valid and out_data stable for all 5 cycles, with no mem_rd_en.
REQ-036 Bench SHALL cover: n_win=0 -> done pulse after K filter reads, with out_valid never asserted.
REQ-037 Bench SHALL cover: ifm_base=510, stride 1, K=4 -> read addresses 510, 511, 0, 1.
REQ-038 Bench SHALL cover: rst_n low during COMPUTE -> IDLE, with busy=0, out_valid=0 and mem_rd_en=0 immediately, before the next clk edge.
